serial_xfer_scheduler: RTL
==========================

Name: serial_xfer_scheduler

Overview:
- Shares the serial A-in / B-latch / C-out datapath between NREQ requesters using round-robin arbitration.
- Runs one complete transaction per grant: latch B, shift A in, latch C, shift C out.
- Drives the datapath strobes and a requester-select for the operand/result muxes.
- Sits between the requester ports and the shift/latch registers, in place of ad-hoc per-requester sequencing.

Parameters:
- NREQ, 2, number of requesters (2..4).
- A_BEATS, 4, shiftA cycles per transaction (1..16).
- C_BEATS, 4, shiftC cycles per transaction (1..16).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req  in  NREQ  per-requester transaction request; level, sampled only in IDLE.
- abort  in  1  synchronous abort of the current transaction.
- gnt  out  NREQ  one-hot owner of the datapath; all zero when idle.
- sel  out  2  binary index of the current owner; 0 when idle.
- busy  out  1  high in any state except IDLE.
- done  out  NREQ  one-cycle completion pulse to the owner.
- latchB  out  1  load B operand register.
- shiftA  out  1  shift A register one beat.
- latchC  out  1  capture result into C register.
- shiftC  out  1  shift C register one beat.
- startC  out  1  marks the first C beat.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE, beat counter to 0, last-grant pointer to NREQ-1 (requester 0 has first priority).
  - All outputs are 0.
  - Reset may assert in any state, including mid-transaction. No done pulse is generated and no strobe glitches high.
- Output timing: strobes, gnt, sel, busy and done are decoded only from registered state, counter and owner. There is no combinational path from req or abort to any output.
- States and transitions:
  - IDLE: if any req bit is set, pick the first set bit searching from (last+1) mod NREQ upward with wrap. Register it as owner and go to LOADB. Otherwise stay in IDLE.
  - LOADB: latchB=1 for exactly one cycle, then go to SHIFTA with counter=0.
  - SHIFTA: shiftA=1 every cycle. The counter increments each cycle. When counter==A_BEATS-1, clear the counter and go to LATCHC.
  - LATCHC: latchC=1 for one cycle, then go to SENDC with counter=0.
  - SENDC: shiftC=1 every cycle; startC=1 only when counter==0. When counter==C_BEATS-1, go to DONE.
  - DONE: done[owner]=1 for one cycle. Set last=owner, then go to IDLE.
- Grant signals: gnt[owner]=1 and sel=owner in every state from LOADB through DONE inclusive.
- Latency and occupancy:
  - req is sampled at edge N; latchB and gnt are high in the cycle after edge N.
  - Transaction occupancy is A_BEATS+C_BEATS+3 cycles (11 at defaults).
  - IDLE lasts at least one cycle between transactions, so back-to-back transactions are spaced A_BEATS+C_BEATS+4 cycles apart.
- Requests during a transaction: req is ignored from LOADB through DONE. Dropping req mid-transaction does not stop it; it completes and pulses done.
- Abort:
  - abort=1 in LOADB, SHIFTA, LATCHC or SENDC returns the block to IDLE at the next edge.
  - No done pulse. Counter is cleared. last=owner, so the aborted requester loses priority.
  - abort in IDLE or DONE is ignored.
- Fairness: a requester holding req continuously waits at most NREQ-1 transactions.

Test Plan:
- Single request: req=01 for 1 cycle after reset.
  - gnt=01 from the next cycle for 11 cycles.
  - latchB in cycle 1, shiftA in cycles 2-5, latchC in cycle 6, shiftC in cycles 7-10 with startC only in cycle 7, done=01 in cycle 11, then busy=0.
- Simultaneous requests: req=11 held from reset.
  - Grants alternate 0,1,0,1, each done pulse going to the matching owner.
  - Each new grant starts 12 cycles after the previous one.
- Abort: with req0 granted, assert abort in the 3rd shiftA cycle while req=11.
  - Block is in IDLE next cycle, no done, counter 0.
  - Next grant goes to requester 1.
- Request dropped: req1 granted, then req1 deasserted during SHIFTA.
  - Full sequence completes and done=10 pulses.
- Reset mid-transfer: assert rst_n=0 asynchronously during the 2nd SENDC cycle.
  - All outputs are 0 immediately.
  - After release with req=11, requester 0 is granted first.
- Parameter variant: A_BEATS=1, C_BEATS=1, NREQ=3, req=100.
  - Exactly 1 shiftA and 1 shiftC cycle, with startC coincident with shiftC.
  - gnt=100, sel=2, occupancy 5 cycles.

Source files
------------

// File: rtl/serial_xfer_scheduler.sv
// Round-robin scheduler that time-shares the serial A-in / B-latch / C-out
// datapath between NREQ requesters, one full transaction per grant.
module serial_xfer_scheduler #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned A_BEATS = 4,
  parameter int unsigned C_BEATS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            abort,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      sel,
  output logic            busy,
  output logic [NREQ-1:0] done,
  output logic            latchB,
  output logic            shiftA,
  output logic            latchC,
  output logic            shiftC,
  output logic            startC
);

  localparam int unsigned CW = 4;
  localparam int unsigned IW = (NREQ > 2) ? 2 : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOADB  = 3'd1;
  localparam logic [2:0] S_SHIFTA = 3'd2;
  localparam logic [2:0] S_LATCHC = 3'd3;
  localparam logic [2:0] S_SENDC  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      last_q, last_d;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            latchb_q, latchb_d;
  logic            shifta_q, shifta_d;
  logic            latchc_q, latchc_d;
  logic            shiftc_q, shiftc_d;
  logic            startc_q, startc_d;

  logic            pick_found_c;
  logic [1:0]      pick_c;
  int unsigned     rr_idx;
  logic [NREQ-1:0] oh_d;

  // Round-robin search starting just after the last owner, with wrap.
  always_comb begin
    pick_found_c = 1'b0;
    pick_c       = 2'd0;
    rr_idx       = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      rr_idx = (32'(last_q) + i) % NREQ;
      if (!pick_found_c && req[IW'(rr_idx)]) begin
        pick_found_c = 1'b1;
        pick_c       = 2'(rr_idx);
      end
    end
  end

  // Next state, beat counter, owner and priority pointer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pick_found_c) begin
          owner_d = pick_c;
          state_d = S_LOADB;
        end
      end
      S_LOADB: begin
        cnt_d   = '0;
        state_d = S_SHIFTA;
      end
      S_SHIFTA: begin
        if (cnt_q == CW'(A_BEATS - 1)) begin
          cnt_d   = '0;
          state_d = S_LATCHC;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCHC: begin
        cnt_d   = '0;
        state_d = S_SENDC;
      end
      S_SENDC: begin
        if (cnt_q == CW'(C_BEATS - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    // Abort drops the transaction silently; the aborted owner loses priority.
    if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      last_d  = owner_q;
    end
  end

  // Output decode from next-state values so every output is a flop.
  always_comb begin
    oh_d     = NREQ'(1) << owner_d;
    busy_d   = (state_d != S_IDLE);
    gnt_d    = busy_d ? oh_d : '0;
    sel_d    = busy_d ? owner_d : 2'd0;
    done_d   = (state_d == S_DONE) ? oh_d : '0;
    latchb_d = (state_d == S_LOADB);
    shifta_d = (state_d == S_SHIFTA);
    latchc_d = (state_d == S_LATCHC);
    shiftc_d = (state_d == S_SENDC);
    startc_d = (state_d == S_SENDC) && (cnt_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      owner_q  <= 2'd0;
      last_q   <= 2'(NREQ - 1);
      gnt_q    <= '0;
      sel_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= '0;
      latchb_q <= 1'b0;
      shifta_q <= 1'b0;
      latchc_q <= 1'b0;
      shiftc_q <= 1'b0;
      startc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      latchb_q <= latchb_d;
      shifta_q <= shifta_d;
      latchc_q <= latchc_d;
      shiftc_q <= shiftc_d;
      startc_q <= startc_d;
    end
  end

  assign gnt    = gnt_q;
  assign sel    = sel_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign latchB = latchb_q;
  assign shiftA = shifta_q;
  assign latchC = latchc_q;
  assign shiftC = shiftc_q;
  assign startC = startc_q;

endmodule
